prg_lfsr_scheduler: RTL and testbench
=====================================

// Module: prg_lfsr_scheduler
// PURPOSE
//   Shares one 16-bit Fibonacci LFSR pseudo-random generator among NUM_REQ requesters.
//   Owns the LFSR state register and the seed load, including a zero-seed guard.
//   After every seed load it runs a warm-up of discarded steps.
//   It then grants one random word per grant using round-robin arbitration.
//   Sits between the PRG datapath and the client blocks that consume random numbers.
// PARAMETERS
//   NUM_REQ        4        number of requesters (2..16)
//   RANDOM_LENGTH  16       LFSR / random word width
//   WARMUP_CYCLES  16       LFSR steps discarded after reset or seed load (0 = no warm-up)
//   POLYNOMIAL     16'hE801 tap mask; feedback = ^(lfsr & POLYNOMIAL)
// PORTS
//   clk        in   1                clock, rising edge
//   rst        in   1                asynchronous reset, active-high
//   seed_load  in   1                load seed into LFSR this cycle
//   seed       in   RANDOM_LENGTH    seed value; 0 is replaced by 1
//   busy       out  1                1 while in WARMUP (no grants are issued)
//   req        in   NUM_REQ          per-requester request; held until granted
//   gnt        out  NUM_REQ          one-hot grant, registered, 1-cycle pulse
//   rnd_valid  out  1                random word valid; high exactly when gnt != 0
//   rnd_data   out  RANDOM_LENGTH    random word for the granted requester
//   rnd_id     out  $clog2(NUM_REQ)  index of the granted requester
// BEHAVIOUR
//   - Step function: lfsr_next = {^(lfsr & POLYNOMIAL), lfsr[RANDOM_LENGTH-1:1]}.
//     If lfsr == 0 in any state, the next value is 1 (lock-up guard).
//   - Reset values: lfsr=1, state=WARMUP, warm_cnt=0, rr_ptr=0.
//     Outputs at reset: gnt=0, rnd_valid=0, rnd_data=0, rnd_id=0, busy=1.
//   - FSM has two states, WARMUP and SERVE.
//   - WARMUP:
//       lfsr steps every cycle and warm_cnt increments.
//       After WARMUP_CYCLES steps the FSM goes to SERVE and busy falls that edge.
//       With WARMUP_CYCLES=0 the FSM enters SERVE on the first clock after reset or seed load.
//       req is ignored; gnt=0.
//   - SERVE:
//       If req != 0, grant one requester.
//       Priority search starts at rr_ptr and wraps modulo NUM_REQ.
//       Registered results: gnt[k]=1, rnd_id=k, rnd_data=current lfsr, rnd_valid=1.
//       On the same edge the lfsr steps and rr_ptr is set to (k+1)%NUM_REQ.
//       Latency: req sampled at edge N produces gnt/rnd_valid high after edge N, i.e. during cycle N+1.
//       Each grant delivers exactly one word.
//       A requester still holding req after its gnt is re-arbitrated in the next cycle.
//       A requester may withdraw req before it is granted; no grant is then issued to it.
//       If req == 0: gnt=0, rnd_valid=0, rnd_data holds its last value, lfsr behaviour per CONFIGURATION.
//   - seed_load (any state) has priority over arbitration:
//       lfsr <= (seed==0) ? 1 : seed; state <= WARMUP; warm_cnt <= 0; busy <= 1.
//       No grant is issued on that edge; rr_ptr is kept.
//       Requests active on that edge are not lost, since requesters hold req.
//   - seed_load held high: the LFSR reloads every cycle and stays in WARMUP.
//   - rst asserted mid-operation: all state returns to reset values immediately.
//     Any in-flight gnt/rnd_valid is dropped.
//   - Fairness: with all req high, grants rotate 0,1,...,NUM_REQ-1,0...; no requester waits more than NUM_REQ cycles.
// CONFIGURATION
//   PRG_FREE_RUN_EN defined:
//     In SERVE the lfsr steps every cycle, whether or not a grant occurs.
//     Output words then depend on request timing.
//   PRG_FREE_RUN_EN undefined (default):
//     In SERVE the lfsr steps only on a grant.
//     The word sequence is then fixed by the seed, independent of request timing.
//   WARMUP behaviour is identical in both builds.
// TESTING
//   1. Reset, WARMUP_CYCLES=16, no req -> busy=1 for 16 cycles after rst falls, then 0; gnt stays 0 throughout.
//   2. WARMUP_CYCLES=0, seed_load with seed=16'hACE1, then req=4'b0100 held
//      -> gnt=4'b0100 and rnd_id=2 each cycle; rnd_data = 16'hACE1, 16'h5670, 16'hAB38.
//   3. WARMUP_CYCLES=0, seed=0 loaded -> first granted rnd_data = 16'h0001.
//   4. req=4'b1111 held in SERVE -> rnd_id sequence 0,1,2,3,0; every cycle exactly one gnt bit set and rnd_valid=1.
//   5. seed_load together with req=4'b0001 -> no gnt that cycle, busy=1.
//      WARMUP_CYCLES cycles later the first grant goes to requester 0 with the word reached after the warm-up.
//   6. Default build, gaps of 5 idle cycles between single requests -> the word sequence matches back-to-back requests.
//      PRG_FREE_RUN_EN build -> the lfsr advances 6 steps between those grants.

Source files
------------

// File: rtl/prg_lfsr_scheduler.sv
// prg_lfsr_scheduler
//   Shares one Fibonacci LFSR among NUM_REQ requesters. After reset or a seed
//   load the LFSR runs WARMUP_CYCLES discarded steps, then each round-robin
//   grant hands out the current LFSR word and advances the generator.
//   Optional build macro: PRG_FREE_RUN_EN -- when defined the LFSR also steps
//   on idle SERVE cycles; when undefined it steps only on a grant, so the word
//   sequence depends on the seed alone.
module prg_lfsr_scheduler #(
    parameter int                         NUM_REQ       = 4,
    parameter int                         RANDOM_LENGTH = 16,
    parameter int                         WARMUP_CYCLES = 16,
    parameter logic [RANDOM_LENGTH-1:0]   POLYNOMIAL    = 16'hE801
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          seed_load,
    input  logic [RANDOM_LENGTH-1:0]      seed,
    output logic                          busy,
    input  logic [NUM_REQ-1:0]            req,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          rnd_valid,
    output logic [RANDOM_LENGTH-1:0]      rnd_data,
    output logic [$clog2(NUM_REQ)-1:0]    rnd_id
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(WARMUP_CYCLES + 2);

    typedef enum logic {WARMUP, SERVE} state_t;

    state_t                   state, state_next;
    logic [CNT_W-1:0]         warm_cnt, warm_cnt_next;
    logic [RANDOM_LENGTH-1:0] lfsr, lfsr_next, lfsr_step;
    logic [ID_W-1:0]          rr_ptr, rr_ptr_next;
    logic [ID_W-1:0]          pick;
    logic                     found;
    logic                     do_grant;
    int                       idx;

    // One LFSR step, with the all-zero lock-up state forced back to 1.
    always_comb begin
        if (lfsr == '0) begin
            lfsr_step = RANDOM_LENGTH'(1);
        end else begin
            lfsr_step = {^(lfsr & POLYNOMIAL), lfsr[RANDOM_LENGTH-1:1]};
        end
    end

    // Round-robin search: first active request at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    // Next-state logic: seed load first, then warm-up stepping or arbitration.
    always_comb begin
        state_next    = state;
        warm_cnt_next = warm_cnt;
        lfsr_next     = lfsr;
        rr_ptr_next   = rr_ptr;
        do_grant      = 1'b0;

        if (seed_load) begin
            lfsr_next     = (seed == '0) ? RANDOM_LENGTH'(1) : seed;
            state_next    = WARMUP;
            warm_cnt_next = '0;
        end else begin
            case (state)
                WARMUP: begin
                    if (WARMUP_CYCLES == 0) begin
                        state_next = SERVE;
                    end else begin
                        lfsr_next     = lfsr_step;
                        warm_cnt_next = warm_cnt + 1'b1;
                        if (warm_cnt == CNT_W'(WARMUP_CYCLES - 1)) begin
                            state_next = SERVE;
                        end
                    end
                end
                SERVE: begin
                    if (found) begin
                        do_grant    = 1'b1;
                        lfsr_next   = lfsr_step;
                        rr_ptr_next = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                    end else begin
`ifdef PRG_FREE_RUN_EN
                        lfsr_next = lfsr_step;
`else
                        lfsr_next = (lfsr == '0) ? RANDOM_LENGTH'(1) : lfsr;
`endif
                    end
                end
                default: state_next = WARMUP;
            endcase
        end
    end

    // State, LFSR and arbitration pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state    <= WARMUP;
            warm_cnt <= '0;
            lfsr     <= RANDOM_LENGTH'(1);
            rr_ptr   <= '0;
            busy     <= 1'b1;
        end else begin
            state    <= state_next;
            warm_cnt <= warm_cnt_next;
            lfsr     <= lfsr_next;
            rr_ptr   <= rr_ptr_next;
            busy     <= (state_next == WARMUP);
        end
    end

    // Registered grant outputs; rnd_data and rnd_id hold between grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
            rnd_id    <= '0;
        end else begin
            gnt       <= do_grant ? (NUM_REQ'(1) << pick) : '0;
            rnd_valid <= do_grant;
            if (do_grant) begin
                rnd_data <= lfsr;
                rnd_id   <= pick;
            end
        end
    end

endmodule

// File: tb/tb_prg_lfsr_scheduler.sv
// tb_prg_lfsr_scheduler
//   Two instances share stimulus: one with a 16-step warm-up, one with none.
//   The reference model tracks each instance as "seed plus number of LFSR
//   steps taken" and derives words by advancing the seed from scratch.
module tb_prg_lfsr_scheduler;

    localparam int          N    = 4;
    localparam int          RL   = 16;
    localparam logic [15:0] POLY = 16'hE801;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [15:0] seed = '0;
    logic [3:0]  req = '0;

    logic        busy_o  [2];
    logic [3:0]  gnt_o   [2];
    logic        valid_o [2];
    logic [15:0] data_o  [2];
    logic [1:0]  id_o    [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, per instance.
    int          warm     [2] = '{16, 0};
    bit          m_serving[2];
    int          m_since  [2];
    logic [15:0] m_base   [2];
    int          m_steps  [2];
    int          m_rr     [2];
    logic [3:0]  m_gnt    [2];
    logic        m_valid  [2];
    logic [15:0] m_data   [2];
    logic [1:0]  m_id     [2];
    logic        m_busy   [2];

    always #5 clk = ~clk;

    prg_lfsr_scheduler #(.NUM_REQ(N), .RANDOM_LENGTH(RL), .WARMUP_CYCLES(16), .POLYNOMIAL(POLY)) dut_a (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .busy(busy_o[0]),
        .req(req), .gnt(gnt_o[0]), .rnd_valid(valid_o[0]), .rnd_data(data_o[0]), .rnd_id(id_o[0])
    );

    prg_lfsr_scheduler #(.NUM_REQ(N), .RANDOM_LENGTH(RL), .WARMUP_CYCLES(0), .POLYNOMIAL(POLY)) dut_b (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .busy(busy_o[1]),
        .req(req), .gnt(gnt_o[1]), .rnd_valid(valid_o[1]), .rnd_data(data_o[1]), .rnd_id(id_o[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance a word n times by the generator rule.
    function automatic logic [15:0] adv(input logic [15:0] s, input int n);
        logic [15:0] w = s;
        for (int j = 0; j < n; j++) begin
            if (w == 16'h0) w = 16'h1;
            else            w = {^(w & POLY), w[15:1]};
        end
        return w;
    endfunction

    task automatic model_reset(input int i);
        m_serving[i] = 1'b0;
        m_since[i]   = 0;
        m_base[i]    = 16'h1;
        m_steps[i]   = 0;
        m_rr[i]      = 0;
        m_gnt[i]     = '0;
        m_valid[i]   = 1'b0;
        m_data[i]    = '0;
        m_id[i]      = '0;
        m_busy[i]    = 1'b1;
    endtask

    task automatic model_edge(input int i);
        int k;
        m_gnt[i]   = '0;
        m_valid[i] = 1'b0;
        if (seed_load) begin
            m_base[i]    = (seed == 16'h0) ? 16'h1 : seed;
            m_steps[i]   = 0;
            m_since[i]   = 0;
            m_serving[i] = 1'b0;
            m_busy[i]    = 1'b1;
        end else if (!m_serving[i]) begin
            if (m_since[i] < warm[i]) begin
                m_steps[i]++;
                m_since[i]++;
            end
            if (m_since[i] >= warm[i]) begin
                m_serving[i] = 1'b1;
                m_busy[i]    = 1'b0;
            end
        end else if (req != 4'b0) begin
            k = m_rr[i];
            while (!req[k]) k = (k + 1) % N;
            m_gnt[i]   = 4'(1 << k);
            m_valid[i] = 1'b1;
            m_id[i]    = 2'(k);
            m_data[i]  = adv(m_base[i], m_steps[i]);
            m_steps[i]++;
            m_rr[i]    = (k + 1) % N;
        end else begin
`ifdef PRG_FREE_RUN_EN
            m_steps[i]++;
`endif
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("gnt%0d", i),   32'(gnt_o[i]),   32'(m_gnt[i]));
            check($sformatf("valid%0d", i), 32'(valid_o[i]), 32'(m_valid[i]));
            check($sformatf("data%0d", i),  32'(data_o[i]),  32'(m_data[i]));
            check($sformatf("id%0d", i),    32'(id_o[i]),    32'(m_id[i]));
            check($sformatf("busy%0d", i),  32'(busy_o[i]),  32'(m_busy[i]));
        end
    endtask

    // One clock edge: update model with the inputs present at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) model_reset(i);
            else     model_edge(i);
        end
        #1;
        compare_all();
    endtask

    initial begin
        logic [15:0] exp_w;
        model_reset(0);
        model_reset(1);

        // Reset state
        tick();
        tick();
        rst = 1'b0;

        // 1: busy high for 16 cycles after reset release, no grants
        for (int c = 1; c <= 16; c++) begin
            tick();
            check("t1_busy", 32'(busy_o[0]), (c < 16) ? 32'd1 : 32'd0);
            check("t1_gnt",  32'(gnt_o[0]), 32'd0);
        end

        // 2: zero warm-up, seed ACE1, requester 2 held
        seed = 16'hACE1; seed_load = 1'b1;
        tick();
        seed_load = 1'b0; req = 4'b0100;
        tick();
        for (int c = 0; c < 3; c++) begin
            tick();
            exp_w = (c == 0) ? 16'hACE1 : (c == 1) ? 16'h5670 : 16'hAB38;
            check("t2_gnt",  32'(gnt_o[1]), 32'h4);
            check("t2_id",   32'(id_o[1]),  32'd2);
            check("t2_data", 32'(data_o[1]), 32'(exp_w));
        end
        req = 4'b0;

        // 3: zero seed is replaced by 1
        seed = 16'h0; seed_load = 1'b1;
        tick();
        seed_load = 1'b0; req = 4'b0001;
        tick();
        tick();
        check("t3_data", 32'(data_o[1]), 32'h1);
        req = 4'b0;
        for (int c = 0; c < 20; c++) tick();

        // 4: all requesting -> rotating grants on the warm-up instance
        req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t4_id",     32'(id_o[0]), 32'(c % N));
            check("t4_onehot", 32'($countones(gnt_o[0])), 32'd1);
            check("t4_valid",  32'(valid_o[0]), 32'd1);
        end

        // 5: seed load wins over a pending request
        seed = 16'h1234; seed_load = 1'b1; req = 4'b0001;
        tick();
        check("t5_gnt",  32'(gnt_o[0]), 32'd0);
        check("t5_busy", 32'(busy_o[0]), 32'd1);
        seed_load = 1'b0;
        for (int c = 0; c < 16; c++) tick();
        tick();
        check("t5_gnt_after", 32'(gnt_o[0]), 32'h1);
        check("t5_data",      32'(data_o[0]), 32'(adv(16'h1234, 16)));
        req = 4'b0;

        // 6: single requests separated by 5 idle cycles
        seed = 16'hACE1; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        tick();
        for (int n = 0; n < 3; n++) begin
            req = 4'b0001;
            tick();
`ifdef PRG_FREE_RUN_EN
            exp_w = adv(16'hACE1, 6 * n);
`else
            exp_w = adv(16'hACE1, n);
`endif
            check("t6_data", 32'(data_o[1]), 32'(exp_w));
            req = 4'b0;
            for (int c = 0; c < 5; c++) tick();
        end

        // Randomized traffic with occasional seed loads and asynchronous resets
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                model_reset(0);
                model_reset(1);
                #1;
                compare_all();
                tick();
                rst = 1'b0;
            end
            seed_load = ($urandom_range(0, 39) == 0);
            seed      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            req       = 4'($urandom_range(0, 15));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
